regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the datapath; successor to the 2R/1W regfile.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_fsm.sv | 53 +++++
 rtl/regfile_mp.sv | 85 ++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int RF_DW_DEF    = 32;
    localparam int RF_DEPTH_DEF = 32;
    localparam int RF_NWR       = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - clear sequencer: zeroes one entry per cycle, then enters RUN
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int DEPTH = RF_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output rf_state_t     state,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    logic [AW-1:0] ptr;

    // Entry 0 is never stored, so the sweep starts at 1 and ends at DEPTH-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= AW'(1);
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= AW'(1);
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= AW'(1);
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NRD async-read / 2 sync-write register file; REGFILE_BYPASS_EN forwards same-cycle writes
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int DW    = RF_DW_DEF,
    parameter  int DEPTH = RF_DEPTH_DEF,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_req,
    output logic                 ready,
    input  logic [RF_NWR-1:0]    writeEn,
    input  logic [RF_NWR*AW-1:0] rw,
    input  logic [RF_NWR*DW-1:0] busW,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*DW-1:0]    busR
);

    rf_state_t     state;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_addr [RF_NWR];
    logic [DW-1:0] wr_data [RF_NWR];
    logic          wr_go   [RF_NWR];

    regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .state    (state),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A write lands only in RUN, outside reset, when no clear is starting, and on a real entry.
    always_comb begin
        for (int p = 0; p < RF_NWR; p++) begin
            wr_addr[p] = rw[p*AW +: AW];
            wr_data[p] = busW[p*DW +: DW];
            wr_go[p]   = rst_n && (state == RUN) && !clr_req && writeEn[p] &&
                         (wr_addr[p] != '0) && (32'(wr_addr[p]) < DEPTH);
        end
    end

    // Later ports are assigned last, so port 1 wins an address collision.
    always_ff @(posedge clk) begin
        if (rst_n && clr_we) begin
            mem[clr_addr] <= '0;
        end
        for (int p = 0; p < RF_NWR; p++) begin
            if (wr_go[p]) begin
                mem[wr_addr[p]] <= wr_data[p];
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] rd_data;

        always_comb begin
            rd_addr = ra[r*AW +: AW];
            rd_data = '0;
            if ((state == RUN) && (rd_addr != '0) && (32'(rd_addr) < DEPTH)) begin
                rd_data = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < RF_NWR; p++) begin
                    if (wr_go[p] && (wr_addr[p] == rd_addr)) begin
                        rd_data = wr_data[p];
                    end
                end
`endif
            end
        end

        assign busR[r*DW +: DW] = rd_data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed bench with a per-cycle reference model for regfile_mp
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr_req, ready;
    logic [1:0]  we;
    logic [9:0]  rw, ra;
    logic [63:0] busW, busR;

    logic         clr2, ready2;
    logic [1:0]   we2;
    logic [9:0]   rw2;
    logic [63:0]  busW2;
    logic [19:0]  ra2;
    logic [127:0] busR2;

    regfile_mp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .ready   (ready),
        .writeEn (we),
        .rw      (rw),
        .busW    (busW),
        .ra      (ra),
        .busR    (busR)
    );

    regfile_mp #(.DW(32), .DEPTH(24), .NRD(4)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr2),
        .ready   (ready2),
        .writeEn (we2),
        .rw      (rw2),
        .busW    (busW2),
        .ra      (ra2),
        .busR    (busR2)
    );

    int vecs = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: contents array plus "cycles of clearing left"; file reads as all-zero until clear ends.
    logic [31:0] m_mem [32];
    bit          m_ready = 1'b0;
    int          clr_left = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready  = 1'b0;
            clr_left = 31;
        end else if (!m_ready) begin
            clr_left--;
            if (clr_left == 0) m_ready = 1'b1;
        end else if (clr_req) begin
            m_ready  = 1'b0;
            clr_left = 31;
        end else begin
            if (we[0] && rw[4:0] != 5'd0) m_mem[rw[4:0]] = busW[31:0];
            if (we[1] && rw[9:5] != 5'd0) m_mem[rw[9:5]] = busW[63:32];
        end
        if (!m_ready) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        if (!m_ready || a == 5'd0) return 32'd0;
        v = m_mem[a];
        if (BYP && rst_n && !clr_req) begin
            if (we[0] && rw[4:0] == a) v = busW[31:0];
            if (we[1] && rw[9:5] == a) v = busW[63:32];
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, ready}, {31'd0, m_ready});
            check("busR0", busR[31:0], exp_rd(ra[4:0]));
            check("busR1", busR[63:32], exp_rd(ra[9:5]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int exp);
        int cnt = 0;
        while (!ready && cnt < 100) begin
            cyc();
            cnt++;
        end
        check(name, 32'(cnt), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr_req = 1'b0; we = 2'b00; rw = '0; busW = '0; ra = '0;
        clr2 = 1'b0; we2 = 2'b00; rw2 = '0; busW2 = '0; ra2 = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("ready_in_reset", {31'd0, ready}, 32'd0);
        rst_n = 1'b1;
        wait_ready("clr_len_boot", 31);

        // Fill the array with garbage so the next clear has something to fix.
        for (int a = 1; a < 32; a++) begin
            we = 2'b01; rw = {5'd0, 5'(a)}; busW = {32'd0, {4{8'(a)}} ^ 32'h5A5A_5A5A};
            cyc();
        end
        we = 2'b00;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        wait_ready("clr_len_reset", 31);
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            cyc();
            check("cleared", busR[31:0], 32'd0);
        end

        // Single write, same-cycle and next-cycle read.
        ra = {5'd0, 5'd5}; we = 2'b01; rw = {5'd0, 5'd5}; busW = {32'd0, 32'hDEAD_BEEF};
        #1 check("t2_same", busR[31:0], BYP ? 32'hDEAD_BEEF : 32'd0);
        cyc();
        we = 2'b00;
        #1 check("t2_next", busR[31:0], 32'hDEAD_BEEF);

        // Collision: port 1 wins; entry 0 stays zero.
        we = 2'b11; rw = {5'd7, 5'd7}; busW = {32'd2, 32'd1}; ra = {5'd7, 5'd0};
        #1 check("t3_same", busR[63:32], BYP ? 32'd2 : 32'd0);
        check("t3_r0_port0", busR[31:0], 32'd0);
        cyc();
        we = 2'b00;
        #1 check("t3_p1wins", busR[63:32], 32'd2);
        we = 2'b01; rw = '0; busW = {2{32'hFFFF_FFFF}}; ra = '0;
        #1 check("t3_r0_same", busR[31:0], 32'd0);
        cyc();
        we = 2'b00;
        #1 check("t3_r0", busR[31:0], 32'd0);

        // Clear request from RUN; a write in the same cycle is lost.
        we = 2'b01; rw = {5'd0, 5'd3}; busW = {32'd0, 32'd9};
        cyc();
        we = 2'b00; ra = {5'd4, 5'd3};
        #1 check("t4_pre", busR[31:0], 32'd9);
        clr_req = 1'b1; we = 2'b01; rw = {5'd0, 5'd4}; busW = {32'd0, 32'hAA};
        cyc();
        clr_req = 1'b0; we = 2'b00;
        #1 check("t4_ready_low", {31'd0, ready}, 32'd0);
        check("t4_rd3_clear", busR[31:0], 32'd0);
        wait_ready("clr_len_req", 31);
        #1 check("t4_rd3_after", busR[31:0], 32'd0);
        check("t4_lost_wr", busR[63:32], 32'd0);

        // Reset in the middle of a clear restarts the sweep.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        check("t5_midclear", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        wait_ready("clr_len_restart", 31);

        // Second configuration: 4 read ports, 24 entries.
        check("t6_ready", {31'd0, ready2}, 32'd1);
        we2 = 2'b11; rw2 = {5'd2, 5'd1}; busW2 = {32'h22, 32'h11};
        cyc();
        rw2 = {5'd23, 5'd3}; busW2 = {32'h2323, 32'h33};
        cyc();
        we2 = 2'b01; rw2 = {5'd0, 5'd30}; busW2 = {32'd0, 32'hFFFF_FFFF};
        cyc();
        we2 = 2'b00; ra2 = {5'd23, 5'd3, 5'd2, 5'd1};
        #1 check("t6_rd1", busR2[31:0], 32'h11);
        check("t6_rd2", busR2[63:32], 32'h22);
        check("t6_rd3", busR2[95:64], 32'h33);
        check("t6_rd23", busR2[127:96], 32'h2323);
        ra2[4:0] = 5'd30;
        #1 check("t6_rd30", busR2[31:0], 32'd0);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
